// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard/bus status inputs and pipeline control outputs for pipe_ctrl.
// Handshake: redirect_valid is a single-cycle strobe with no ready; the PC register must take redirect_pc whenever it is high.
interface pipe_ctrl_if #(parameter int CNT_W = 32);
  logic             fwd_stall;
  logic             ibus_busy;
  logic             dbus_busy;
  logic             md_busy;
  logic             exc_valid;
  logic [31:0]      exc_target;
  logic             en_if;
  logic             en_id;
  logic             en_ex;
  logic             en_mm;
  logic             en_wb;
  logic             flush_id;
  logic             flush_ex;
  logic             flush_mm;
  logic             flush_wb;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic             drain_err;
  logic             dbg_state;

  modport master (
    output fwd_stall, ibus_busy, dbus_busy, md_busy, exc_valid, exc_target,
    input  en_if, en_id, en_ex, en_mm, en_wb,
    input  flush_id, flush_ex, flush_mm, flush_wb,
    input  redirect_valid, redirect_pc, stall_cnt, drain_err, dbg_state
  );

  modport slave (
    input  fwd_stall, ibus_busy, dbus_busy, md_busy, exc_valid, exc_target,
    output en_if, en_id, en_ex, en_mm, en_wb,
    output flush_id, flush_ex, flush_mm, flush_wb,
    output redirect_valid, redirect_pc, stall_cnt, drain_err, dbg_state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage enables/bubbles, PC redirect, exception-drain FSM,
// drain watchdog and saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int CNT_W    = 32,
    parameter int DRAIN_TO = 255
) (
    input logic     clk,
    input logic     rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [15:0]      DRAIN_LIM = 16'(DRAIN_TO);
    localparam logic [15:0]      DRAIN_ONE = 16'd1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [31:0]      pend_pc;
    logic [15:0]      drain_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             drain_err;

    logic        en_if, en_id, en_ex, en_mm, en_wb;
    logic        flush_id, flush_ex, flush_mm, flush_wb;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // A flushed stage keeps its enable high so the bubble is actually loaded.
    always_comb begin
        en_if          = 1'b1;
        en_id          = 1'b1;
        en_ex          = 1'b1;
        en_mm          = 1'b1;
        en_wb          = 1'b1;
        flush_id       = 1'b0;
        flush_ex       = 1'b0;
        flush_mm       = 1'b0;
        flush_wb       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if (rst) begin
            {en_if, en_id, en_ex, en_mm, en_wb} = 5'b00000;
            {flush_id, flush_ex, flush_mm, flush_wb} = 4'b1111;
        end else if (state == DRAIN) begin
            en_if    = 1'b0;
            flush_id = 1'b1;
            if (!bus.ibus_busy) begin
                redirect_valid = 1'b1;
                redirect_pc    = pend_pc;
            end
        end else if (bus.exc_valid) begin
            {flush_id, flush_ex, flush_mm, flush_wb} = 4'b1111;
            if (!bus.ibus_busy) begin
                redirect_valid = 1'b1;
                redirect_pc    = bus.exc_target;
            end else begin
                en_if = 1'b0;
            end
        end else if (bus.dbus_busy) begin
            {en_if, en_id, en_ex, en_mm, en_wb} = 5'b00000;
        end else if (bus.md_busy) begin
            {en_if, en_id, en_ex} = 3'b000;
            flush_mm = 1'b1;
        end else if (bus.fwd_stall) begin
            {en_if, en_id} = 2'b00;
            flush_ex = 1'b1;
        end else if (bus.ibus_busy) begin
            en_if    = 1'b0;
            flush_id = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            pend_pc   <= 32'h0;
            drain_cnt <= 16'h0;
            stall_cnt <= '0;
            drain_err <= 1'b0;
        end else begin
            if (!en_if && !redirect_valid && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            case (state)
                RUN: begin
                    if (bus.exc_valid && bus.ibus_busy) begin
                        state     <= DRAIN;
                        pend_pc   <= bus.exc_target;
                        drain_cnt <= 16'h0;
                    end
                end
                DRAIN: begin
                    if (!bus.ibus_busy) begin
                        state     <= RUN;
                        drain_cnt <= 16'h0;
                    end else if (drain_cnt != DRAIN_LIM) begin
                        // Watchdog only reports; the fetch is still awaited.
                        drain_cnt <= drain_cnt + DRAIN_ONE;
                        if (drain_cnt == DRAIN_LIM - DRAIN_ONE)
                            drain_err <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.en_if          = en_if;
    assign bus.en_id          = en_id;
    assign bus.en_ex          = en_ex;
    assign bus.en_mm          = en_mm;
    assign bus.en_wb          = en_wb;
    assign bus.flush_id       = flush_id;
    assign bus.flush_ex       = flush_ex;
    assign bus.flush_mm       = flush_mm;
    assign bus.flush_wb       = flush_wb;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.stall_cnt      = stall_cnt;
    assign bus.drain_err      = drain_err;
    assign bus.dbg_state      = (state == DRAIN);

endmodule
